// File: rtl/multicycle_control_if.sv
// Control bus between the multicycle MIPS controller and its datapath.
// The controller is the master: it reads IR fields and flags, and drives
// every select, strobe and status signal.
interface multicycle_control_if #(
  parameter int CNT_W = 16
);
  logic [5:0]       Op;
  logic [5:0]       Funct;
  logic             Zero;
  logic             MemReady;
  logic             IorD;
  logic             MemWrite;
  logic             IRWrite;
  logic             RegDst;
  logic             MemtoReg;
  logic             RegWrite;
  logic             ALUSrcA;
  logic [1:0]       ALUSrcB;
  logic [2:0]       ALUControl;
  logic [1:0]       PCSrc;
  logic             PCEn;
  logic             Branch;
  logic             Illegal;
  logic [3:0]       State;
  logic [CNT_W-1:0] RetireCount;

  modport master (
    input  Op, Funct, Zero, MemReady,
    output IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, Branch,
           Illegal, State, RetireCount
  );

  modport slave (
    output Op, Funct, Zero, MemReady,
    input  IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
           ALUSrcA, ALUSrcB, ALUControl, PCSrc, PCEn, Branch,
           Illegal, State, RetireCount
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle MIPS controller: Moore FSM sequencing a shared-memory,
// shared-ALU datapath. Handles memory wait states, flags illegal
// instructions (sticky) and counts retired instructions.
module multicycle_control #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  multicycle_control_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11,
    S_TRAP     = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // R-type funct codes this core implements
  function automatic logic funct_legal(input logic [5:0] f);
    case (f)
      6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  function automatic logic [2:0] funct_alu(input logic [5:0] f);
    case (f)
      6'b100010: return ALU_SUB;
      6'b100100: return ALU_AND;
      6'b100101: return ALU_OR;
      6'b101010: return ALU_SLT;
      default:   return ALU_ADD;
    endcase
  endfunction

  state_t           state, state_nxt;
  logic             illegal_q;
  logic [CNT_W-1:0] retire_q;

  logic       iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write;
  logic       alu_src_a, pc_write, branch_c, retire_evt;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctl;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_nxt;
  end

  // Next-state and Moore outputs (MemReady gates only the wait states)
  always_comb begin
    state_nxt  = S_FETCH;
    iord       = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_ctl    = ALU_ADD;
    pc_src     = 2'b00;
    pc_write   = 1'b0;
    branch_c   = 1'b0;
    retire_evt = 1'b0;
    case (state)
      S_FETCH: begin
        alu_src_b = 2'b01;
        ir_write  = bus.MemReady;
        pc_write  = bus.MemReady;
        state_nxt = bus.MemReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        // Branch target is computed speculatively into ALUOut
        alu_src_b = 2'b11;
        case (bus.Op)
          OP_LW, OP_SW: state_nxt = S_MEMADR;
          OP_RTYPE:     state_nxt = funct_legal(bus.Funct) ? S_EXECUTE : S_TRAP;
          OP_BEQ:       state_nxt = S_BRANCH;
          OP_ADDI:      state_nxt = S_ADDIEXEC;
          OP_J:         state_nxt = S_JUMP;
          default:      state_nxt = S_TRAP;
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = (bus.Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        iord      = 1'b1;
        state_nxt = bus.MemReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        mem_to_reg = 1'b1;
        reg_write  = 1'b1;
        retire_evt = 1'b1;
      end
      S_MEMWRITE: begin
        iord       = 1'b1;
        mem_write  = 1'b1;
        retire_evt = bus.MemReady;
        state_nxt  = bus.MemReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        alu_ctl   = funct_alu(bus.Funct);
        state_nxt = S_ALUWB;
      end
      S_ALUWB: begin
        reg_dst    = 1'b1;
        reg_write  = 1'b1;
        retire_evt = 1'b1;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        alu_ctl    = ALU_SUB;
        pc_src     = 2'b01;
        branch_c   = 1'b1;
        retire_evt = 1'b1;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        state_nxt = S_ADDIWB;
      end
      S_ADDIWB: begin
        reg_write  = 1'b1;
        retire_evt = 1'b1;
      end
      S_JUMP: begin
        pc_src     = 2'b10;
        pc_write   = 1'b1;
        retire_evt = 1'b1;
      end
      default: state_nxt = S_FETCH;  // TRAP and unused codes
    endcase
  end

  // Sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      illegal_q <= 1'b0;
      retire_q  <= '0;
    end else begin
      if (state == S_TRAP) illegal_q <= 1'b1;
      if (retire_evt)      retire_q  <= retire_q + 1'b1;
    end
  end

  // Strobes are qualified by rst_n so nothing can fire while reset is held
  assign bus.IorD        = iord;
  assign bus.MemWrite    = mem_write & rst_n;
  assign bus.IRWrite     = ir_write & rst_n;
  assign bus.RegDst      = reg_dst;
  assign bus.MemtoReg    = mem_to_reg;
  assign bus.RegWrite    = reg_write & rst_n;
  assign bus.ALUSrcA     = alu_src_a;
  assign bus.ALUSrcB     = alu_src_b;
  assign bus.ALUControl  = alu_ctl;
  assign bus.PCSrc       = pc_src;
  assign bus.PCEn        = (pc_write | (branch_c & bus.Zero)) & rst_n;
  assign bus.Branch      = branch_c & rst_n;
  assign bus.Illegal     = illegal_q;
  assign bus.State       = state;
  assign bus.RetireCount = retire_q;

endmodule
